// File: rtl/spu_valid_drain.sv
// spu_valid_drain: receiving end of a cke-stalled valid/data pipeline.
// Captures the last stage's registered output into a first-word-fall-through
// register FIFO and presents it downstream as a ready/valid stream. The
// upstream cke is produced here so the pipeline only advances when the FIFO
// is guaranteed to have room for whatever sits at the pipeline output.
//
// Ports:
//   clk      clock, all state updates on posedge
//   reset    synchronous, active-high reset
//   cke      registered clock enable for every upstream stage
//   s_valid  registered valid from the last upstream stage (held while cke=0)
//   s_data   payload accompanying s_valid
//   m_valid  FIFO non-empty
//   m_ready  downstream accept
//   m_data   head-of-FIFO payload, meaningful when m_valid=1
//   count    current FIFO occupancy
module spu_valid_drain #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             cke,
  input  logic                             s_valid,
  input  logic [DATA_WIDTH-1:0]            s_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  // Reject degenerate depths at elaboration.
  if (FIFO_DEPTH < 2) begin : g_depth_check
    $error("spu_valid_drain: FIFO_DEPTH must be >= 2");
  end

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  cke_q, cke_d;
  logic                  push;
  logic                  pop;

  // The upstream output register is replaced on every cke=1 edge, so it is
  // captured exactly then; while cke=0 it is a held copy and must be ignored.
  assign push    = s_valid & cke_q;
  assign m_valid = (count_q != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = mem_q[rd_ptr_q];
  assign cke     = cke_q;
  assign count   = count_q;

  // Next-state: pointers with wrap, occupancy, and the room-for-one-more enable.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Enabling the pipeline only when a slot is free for next cycle's item
    // is what makes overflow impossible.
    cke_d = (count_d < FULL_CNT);
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cke_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cke_q    <= cke_d;
    end
  end

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // A push while already full means the cke handshake has been broken.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
                                   !(push && (count_q == FULL_CNT)))
    else $error("spu_valid_drain: push while FIFO full");

endmodule
